// File: rtl/fpu_denorm_rshift_pkg.sv
// Shared FPU denormaliser definitions: datapath widths, shift step and the
// encodings of the denormaliser state machine.
package fpu_denorm_rshift_pkg;

  localparam int DN_FRAC_W  = 54;  // fraction width, hidden and guard bits included
  localparam int DN_SHAMT_W = 6;   // shift amount width, max shift 63
  localparam int DN_STEP    = 8;   // coarse shift distance per cycle
  localparam int DN_SH_W    = 4;   // width of a single-cycle shift amount (0..8)

  typedef enum logic [1:0] {
    DN_IDLE  = 2'd0,
    DN_SHIFT = 2'd1,
    DN_DONE  = 2'd2
  } dn_state_e;

endpackage

// File: rtl/fpu_denorm_rshift_rsh8.sv
// Single-cycle right shifter by 0..8 bit positions, with a sticky output that
// collects every bit pushed off the low end. Serves both the coarse and the
// fine shift of the iterative denormaliser.
module fpu_denorm_rsh8
  import fpu_denorm_rshift_pkg::*;
#(
  parameter int DATA_W = DN_FRAC_W
) (
  input  logic [DATA_W-1:0]  i_frac,
  input  logic [DN_SH_W-1:0] i_shamt,
  output logic [DATA_W-1:0]  o_frac,
  output logic               o_sticky
);

  logic [DATA_W-1:0] w_one;
  logic [DATA_W-1:0] w_mask;

  // Mask of the low i_shamt bits, i.e. the bits about to be discarded.
  assign w_one    = DATA_W'(1);
  assign w_mask   = (w_one << i_shamt) - w_one;
  assign o_frac   = i_frac >> i_shamt;
  assign o_sticky = |(i_frac & w_mask);

endmodule

// File: rtl/fpu_denorm_rshift.sv
// Iterative right-shift denormaliser for the FPU result path. A request is
// shifted right STEP bits per cycle while the remaining distance is at least
// STEP, then by the leftover 0..STEP-1 bits in one final cycle. The result
// (fraction, sticky, zero flag) is held in DONE until the consumer takes it.
module fpu_denorm_rshift
  import fpu_denorm_rshift_pkg::*;
#(
  parameter int FRAC_W  = DN_FRAC_W,
  parameter int SHAMT_W = DN_SHAMT_W,
  parameter int STEP    = DN_STEP
) (
  input  logic               rclk,
  input  logic               reset,
  input  logic               in_vld,
  output logic               in_rdy,
  input  logic [FRAC_W-1:0]  in_frac,
  input  logic [SHAMT_W-1:0] in_shamt,
  output logic               out_vld,
  input  logic               out_rdy,
  output logic [FRAC_W-1:0]  out_frac,
  output logic               out_sticky,
  output logic               out_zero,
  output logic               busy
);

  dn_state_e           r_state;
  dn_state_e           w_next;
  logic [FRAC_W-1:0]   r_frac;
  logic [SHAMT_W-1:0]  r_rem;
  logic                r_sticky;
  logic                r_zero;
  logic                w_coarse;
  logic [DN_SH_W-1:0]  w_sh_amt;
  logic [FRAC_W-1:0]   w_sh_frac;
  logic                w_sh_sticky;

  // A coarse step is taken while at least STEP bits of shift remain; the
  // final cycle consumes the remainder, which then fits in the shifter.
  assign w_coarse = (r_rem >= SHAMT_W'(STEP));
  assign w_sh_amt = w_coarse ? DN_SH_W'(STEP) : DN_SH_W'(r_rem);

  fpu_denorm_rsh8 #(
    .DATA_W (FRAC_W)
  ) u_rsh8 (
    .i_frac   (r_frac),
    .i_shamt  (w_sh_amt),
    .o_frac   (w_sh_frac),
    .o_sticky (w_sh_sticky)
  );

  // State register; reset abandons any request in flight.
  always_ff @(posedge rclk or posedge reset) begin
    if (reset) begin
      r_state <= DN_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode: accept only in IDLE, leave SHIFT after the fine cycle,
  // leave DONE on the consumer handshake.
  always_comb begin
    w_next = r_state;
    case (r_state)
      DN_IDLE:  if (in_vld)    w_next = DN_SHIFT;
      DN_SHIFT: if (!w_coarse) w_next = DN_DONE;
      DN_DONE:  if (out_rdy)   w_next = DN_IDLE;
      default:                 w_next = DN_IDLE;
    endcase
  end

  // Handshake and status outputs are pure state decodes.
  always_comb begin
    in_rdy  = 1'b0;
    out_vld = 1'b0;
    busy    = 1'b1;
    case (r_state)
      DN_IDLE: begin
        in_rdy = 1'b1;
        busy   = 1'b0;
      end
      DN_DONE: out_vld = 1'b1;
      default: ;
    endcase
  end

  // Fraction, remaining distance, sticky and zero flag. Inputs are captured
  // only on the accept edge; the zero flag is settled on entry to DONE from
  // the final shifted value so out_zero never depends on a live comparator.
  always_ff @(posedge rclk or posedge reset) begin
    if (reset) begin
      r_frac   <= '0;
      r_rem    <= '0;
      r_sticky <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        DN_IDLE: begin
          if (in_vld) begin
            r_frac   <= in_frac;
            r_rem    <= in_shamt;
            r_sticky <= 1'b0;
            r_zero   <= 1'b0;
          end
        end
        DN_SHIFT: begin
          r_frac   <= w_sh_frac;
          r_sticky <= r_sticky | w_sh_sticky;
          if (w_coarse) begin
            r_rem <= r_rem - SHAMT_W'(STEP);
          end else begin
            r_zero <= (w_sh_frac == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign out_frac   = r_frac;
  assign out_sticky = r_sticky;
  assign out_zero   = r_zero;

endmodule
